// File: rtl/fnd_mode_ctrl_pkg.sv
// Shared types and constants for the FND mode/edit sequencer.
package fnd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_SW,
    ST_WATCH,
    ST_ED_HOUR,
    ST_ED_MIN,
    ST_ED_SEC
  } state_t;

  localparam logic [3:0] BLANK_HI = 4'b1100;
  localparam logic [3:0] BLANK_LO = 4'b0011;

  localparam logic PAGE_SEC = 1'b0;
  localparam logic PAGE_HM  = 1'b1;

  function automatic logic is_edit(state_t s);
    return s inside {ST_ED_HOUR, ST_ED_MIN, ST_ED_SEC};
  endfunction

endpackage

// File: rtl/fnd_mode_ctrl_if.sv
// Button/tick inputs and display/counter controls of the mode sequencer.
interface fnd_mode_ctrl_if;

  logic       i_tick_1khz;
  logic       i_btn_mode;
  logic       i_btn_page;
  logic       i_btn_edit;
  logic       i_btn_up;
  logic       o_src_sel;
  logic       o_page_sel;
  logic [3:0] o_blank;
  logic       o_inc_hour;
  logic       o_inc_min;
  logic       o_inc_sec;
  logic       o_edit;

  modport master (
    output i_tick_1khz, i_btn_mode, i_btn_page,
    output i_btn_edit, i_btn_up,
    input  o_src_sel, o_page_sel, o_blank,
    input  o_inc_hour, o_inc_min, o_inc_sec, o_edit
  );

  modport slave (
    input  i_tick_1khz, i_btn_mode, i_btn_page,
    input  i_btn_edit, i_btn_up,
    output o_src_sel, o_page_sel, o_blank,
    output o_inc_hour, o_inc_min, o_inc_sec, o_edit
  );

endinterface

// File: rtl/fnd_mode_ctrl_blink_timer.sv
// Blink phase generator: toggles phase every BLINK_MS enabled ticks.
module fnd_blink_timer #(
  parameter int BLINK_MS = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  input  logic enable,
  output logic phase
);

  logic [9:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;

  // clear beats a coincident tick
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (enable && tick) begin
      if (cnt_q == 10'(BLINK_MS - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/fnd_mode_ctrl.sv
// FND view/edit sequencer: source/page select, blink mask, inc pulses.
// Optional edit inactivity exit: FND_EDIT_TIMEOUT_EN.
module fnd_mode_ctrl
  import fnd_ctrl_pkg::*;
#(
  parameter int BLINK_MS   = 500,
  parameter int TIMEOUT_MS = 30000
) (
  input logic            clk,
  input logic            reset,
  fnd_mode_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  logic       page_q, page_d;
  logic       src_q, src_d;
  logic       edit_q, edit_d;
  logic [3:0] mask_q, mask_d;
  logic [2:0] inc_q, inc_d;
  logic       act_edit, act_mode;
  logic       act_page, act_up;
  logic       blink_clr;
  logic       phase;
  logic       timeout;

  // one button per cycle: edit > mode > page > up
  always_comb begin
    act_edit = bus.i_btn_edit;
    act_mode = !bus.i_btn_edit && bus.i_btn_mode;
    act_page = !bus.i_btn_edit && !bus.i_btn_mode
               && bus.i_btn_page;
    act_up   = !bus.i_btn_edit && !bus.i_btn_mode
               && !bus.i_btn_page && bus.i_btn_up;
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    inc_d   = '0;
    unique case (state_q)
      ST_SW: begin
        if (act_mode)      state_d = ST_WATCH;
        else if (act_page) page_d  = ~page_q;
      end
      ST_WATCH: begin
        if (act_edit)      state_d = ST_ED_HOUR;
        else if (act_mode) state_d = ST_SW;
        else if (act_page) page_d  = ~page_q;
      end
      ST_ED_HOUR: begin
        if (act_edit)    state_d = ST_ED_MIN;
        else if (act_up) inc_d   = 3'b100;
      end
      ST_ED_MIN: begin
        if (act_edit)    state_d = ST_ED_SEC;
        else if (act_up) inc_d   = 3'b010;
      end
      ST_ED_SEC: begin
        if (act_edit)    state_d = ST_WATCH;
        else if (act_up) inc_d   = 3'b001;
      end
      default: state_d = ST_SW;
    endcase
    if (timeout) state_d = ST_WATCH;

    unique case (state_d)
      ST_ED_HOUR, ST_ED_MIN: page_d = PAGE_HM;
      ST_ED_SEC:             page_d = PAGE_SEC;
      ST_WATCH: if (is_edit(state_q)) page_d = PAGE_HM;
      default: ;
    endcase
  end

  always_comb begin
    src_d     = (state_d != ST_SW);
    edit_d    = is_edit(state_d);
    blink_clr = is_edit(state_d)
                && (state_d != state_q || act_up);
    mask_d    = '0;
    unique case (state_d)
      ST_ED_HOUR, ST_ED_SEC: mask_d = BLANK_HI;
      ST_ED_MIN:             mask_d = BLANK_LO;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SW;
      page_q  <= PAGE_SEC;
      src_q   <= 1'b0;
      edit_q  <= 1'b0;
      mask_q  <= '0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      src_q   <= src_d;
      edit_q  <= edit_d;
      mask_q  <= mask_d;
      inc_q   <= inc_d;
    end
  end

  fnd_blink_timer #(
    .BLINK_MS (BLINK_MS)
  ) u_blink (
    .clk    (clk),
    .reset  (reset),
    .clear  (blink_clr),
    .tick   (bus.i_tick_1khz),
    .enable (edit_q),
    .phase  (phase)
  );

`ifdef FND_EDIT_TIMEOUT_EN
  logic [14:0] idle_q, idle_d;
  logic        any_btn;

  always_comb begin
    any_btn = bus.i_btn_edit | bus.i_btn_mode
              | bus.i_btn_page | bus.i_btn_up;
    idle_d  = idle_q;
    timeout = 1'b0;
    if (!edit_q || any_btn) begin
      idle_d = '0;
    end else if (bus.i_tick_1khz) begin
      if (idle_q == 15'(TIMEOUT_MS - 1)) begin
        timeout = 1'b1;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 15'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_MS > 0);
  assign timeout    = 1'b0;
`endif

  assign bus.o_src_sel  = src_q;
  assign bus.o_page_sel = page_q;
  assign bus.o_edit     = edit_q;
  assign bus.o_blank    = mask_q & {4{phase}};
  assign bus.o_inc_hour = inc_q[2];
  assign bus.o_inc_min  = inc_q[1];
  assign bus.o_inc_sec  = inc_q[0];

endmodule

// File: tb/tb_fnd_mode_ctrl.sv
// Bench for fnd_mode_ctrl: vector table, corner sequences, random vs model.
module tb_fnd_mode_ctrl;

  localparam int BLINK = 4;
  localparam int TMO   = 10;

  // input word: {edit, mode, page, up, tick}
  localparam logic [4:0] B_NO = 5'b00000;
  localparam logic [4:0] B_ED = 5'b10000;
  localparam logic [4:0] B_MO = 5'b01000;
  localparam logic [4:0] B_PG = 5'b00100;
  localparam logic [4:0] B_UP = 5'b00010;
  localparam logic [4:0] B_TK = 5'b00001;

  typedef struct {
    logic [4:0] in;
    logic [9:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  int       m_st, m_n, m_idle;
  bit       m_page;
  bit [2:0] m_inc;

  always #5 clk = ~clk;

  fnd_mode_ctrl_if bus ();

  fnd_mode_ctrl #(
    .BLINK_MS   (BLINK),
    .TIMEOUT_MS (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // output word: {src, page, edit, blank[3:0], inc_h, inc_m, inc_s}
  function automatic logic [9:0] mk(
    bit s, bit p, bit e, logic [3:0] bl, logic [2:0] inc);
    return {s, p, e, bl, inc};
  endfunction

  function automatic logic [9:0] outs();
    return {bus.o_src_sel, bus.o_page_sel, bus.o_edit,
            bus.o_blank, bus.o_inc_hour, bus.o_inc_min,
            bus.o_inc_sec};
  endfunction

  task automatic check(input string nm,
                       input logic [9:0] act,
                       input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] b);
    {bus.i_btn_edit, bus.i_btn_mode, bus.i_btn_page,
     bus.i_btn_up, bus.i_tick_1khz} = b;
  endtask

  task automatic cyc(input logic [4:0] b);
    drive(b);
    @(posedge clk);
    #1;
    drive(B_NO);
  endtask

  task automatic m_reset();
    m_st = 0; m_n = 0; m_idle = 0;
    m_page = 1'b0; m_inc = '0;
  endtask

  task automatic do_reset();
    drive(B_NO);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  // states: 0 sw, 1 watch, 2 hour, 3 min, 4 sec
  // m_n = ticks counted since the blink count was last restarted
  task automatic m_step(input logic [4:0] b);
    bit e, mo, pg, up, tk, any;
    {e, mo, pg, up, tk} = b;
    any = e | mo | pg | up;
    m_inc = '0;
    if (m_st >= 2) begin
      if (e) begin
        if (m_st == 4) begin
          m_st = 1; m_page = 1'b1;
        end else begin
          m_st = m_st + 1;
          m_page = (m_st == 4) ? 1'b0 : 1'b1;
        end
        m_n = 0;
      end else if (!mo && !pg && up) begin
        m_inc = 3'(3'b100 >> (m_st - 2));
        m_n = 0;
      end else if (tk) begin
        m_n = m_n + 1;
      end
`ifdef FND_EDIT_TIMEOUT_EN
      if (any) m_idle = 0;
      else if (tk) begin
        m_idle = m_idle + 1;
        if (m_idle == TMO) begin
          m_st = 1; m_page = 1'b1; m_idle = 0;
        end
      end
`else
      if (any) m_idle = 0;
`endif
    end else begin
      m_idle = 0;
      if (e) begin
        if (m_st == 1) begin
          m_st = 2; m_page = 1'b1; m_n = 0;
        end
      end else if (mo) m_st = 1 - m_st;
      else if (pg) m_page = !m_page;
    end
  endtask

  function automatic logic [9:0] m_out();
    logic [3:0] bl;
    bl = '0;
    if (m_st >= 2 && ((m_n / BLINK) % 2) == 1)
      bl = (m_st == 3) ? 4'b0011 : 4'b1100;
    return {m_st != 0, m_page, m_st >= 2, bl, m_inc};
  endfunction

  function automatic logic [3:0] exp_bl(int k);
    return ((k / BLINK) % 2 == 1) ? 4'b1100 : 4'b0000;
  endfunction

  initial begin
    vec_t     tbl[25];
    logic [4:0] b;
    bit       last_up;
    int       nb;

    tbl[0]  = '{B_MO,        mk(1, 0, 0, 0, 0)};
    tbl[1]  = '{B_MO,        mk(0, 0, 0, 0, 0)};
    tbl[2]  = '{B_MO,        mk(1, 0, 0, 0, 0)};
    tbl[3]  = '{B_ED,        mk(1, 1, 1, 0, 0)};
    tbl[4]  = '{B_ED,        mk(1, 1, 1, 0, 0)};
    tbl[5]  = '{B_ED,        mk(1, 0, 1, 0, 0)};
    tbl[6]  = '{B_ED,        mk(1, 1, 0, 0, 0)};
    tbl[7]  = '{B_PG,        mk(1, 0, 0, 0, 0)};
    tbl[8]  = '{B_UP,        mk(1, 0, 0, 0, 0)};
    tbl[9]  = '{B_ED | B_MO, mk(1, 1, 1, 0, 0)};
    tbl[10] = '{B_ED,        mk(1, 1, 1, 0, 0)};
    tbl[11] = '{B_UP,        mk(1, 1, 1, 0, 3'b010)};
    tbl[12] = '{B_NO,        mk(1, 1, 1, 0, 0)};
    tbl[13] = '{B_UP,        mk(1, 1, 1, 0, 3'b010)};
    tbl[14] = '{B_NO,        mk(1, 1, 1, 0, 0)};
    tbl[15] = '{B_UP,        mk(1, 1, 1, 0, 3'b010)};
    tbl[16] = '{B_NO,        mk(1, 1, 1, 0, 0)};
    tbl[17] = '{B_MO,        mk(1, 1, 1, 0, 0)};
    tbl[18] = '{B_PG,        mk(1, 1, 1, 0, 0)};
    tbl[19] = '{B_ED,        mk(1, 0, 1, 0, 0)};
    tbl[20] = '{B_UP,        mk(1, 0, 1, 0, 3'b001)};
    tbl[21] = '{B_ED,        mk(1, 1, 0, 0, 0)};
    tbl[22] = '{B_MO,        mk(0, 1, 0, 0, 0)};
    tbl[23] = '{B_ED,        mk(0, 1, 0, 0, 0)};
    tbl[24] = '{B_PG,        mk(0, 0, 0, 0, 0)};

    drive(B_NO);
    #2;
    check("reset_async", outs(), '0);
    do_reset();
    check("reset", outs(), '0);

    foreach (tbl[i]) begin
      cyc(tbl[i].in);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // blink cadence from edit entry
`ifdef FND_EDIT_TIMEOUT_EN
    nb = TMO - 1;
`else
    nb = 12;
`endif
    do_reset();
    cyc(B_MO);
    cyc(B_ED);
    check("blink_entry", outs(), mk(1, 1, 1, 0, 0));
    for (int k = 1; k <= nb; k++) begin
      cyc(B_TK);
      check($sformatf("blink_t%0d", k), outs(),
            mk(1, 1, 1, exp_bl(k), 0));
    end

    // btn_up with tick 6: visible again, count restarts
    do_reset();
    cyc(B_MO);
    cyc(B_ED);
    for (int k = 1; k <= 5; k++) cyc(B_TK);
    check("blink_pre_up", outs(), mk(1, 1, 1, 4'b1100, 0));
    cyc(B_TK | B_UP);
    check("blink_up", outs(), mk(1, 1, 1, 0, 3'b100));
    for (int k = 1; k <= 4; k++) begin
      cyc(B_TK);
      check($sformatf("blink_re%0d", k), outs(),
            mk(1, 1, 1, exp_bl(k), 0));
    end

    // reset mid-edit with a pending btn_up
    drive(B_UP);
    reset = 1'b1;
    #1;
    check("rst_mid_async", outs(), '0);
    @(posedge clk);
    #1;
    check("rst_mid_edge", outs(), '0);
    reset = 1'b0;
    drive(B_NO);
    m_reset();
    cyc(B_NO);
    check("rst_mid_after", outs(), '0);

    // idle ticks in seconds edit
    cyc(B_MO);
    cyc(B_ED);
    cyc(B_ED);
    cyc(B_ED);
`ifdef FND_EDIT_TIMEOUT_EN
    for (int k = 1; k < TMO; k++) begin
      cyc(B_TK);
      check($sformatf("tmo_t%0d", k), outs(),
            mk(1, 0, 1, exp_bl(k), 0));
    end
    cyc(B_TK);
    check("tmo_exit", outs(), mk(1, 1, 0, 0, 0));
`else
    for (int k = 1; k <= 12; k++) cyc(B_TK);
    check("no_tmo", outs(), mk(1, 0, 1, exp_bl(12), 0));
`endif

    // random stimulus against the model
    do_reset();
    last_up = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      b[4] = ($urandom_range(0, 11) == 0);
      b[3] = ($urandom_range(0, 11) == 0);
      b[2] = ($urandom_range(0, 11) == 0);
      b[1] = !last_up && ($urandom_range(0, 5) == 0);
      b[0] = ($urandom_range(0, 1) == 0);
      last_up = b[1];
      cyc(b);
      m_step(b);
      check($sformatf("rand%0d", i), outs(), m_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
